// File: rtl/ss_dfifo_pkg.sv
// ss_dfifo_pkg: shared definitions for the copy-channel data FIFO.
//   DF_DW      : width of one buffered data entry (two 32-bit WB words)
//   df_state_e : channel FSM states
package ss_dfifo_pkg;

    localparam int unsigned DF_DW = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } df_state_e;

endpackage

// File: rtl/ss_dfifo_ram.sv
// ss_dfifo_ram: DEPTH x 64-bit storage for ss_dfifo.
//   Synchronous write, asynchronous (show-ahead) read, no reset.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module ss_dfifo_ram
    import ss_dfifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DF_DW-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [DF_DW-1:0] rdata
);

    logic [DF_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ss_dfifo.sv
// ss_dfifo: 64-bit data buffer and flow controller between the source and
// destination ss_sg engines of one copy channel.
// Ports:
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   cmd_start, cmd_abort      : channel start / abort pulses from ss_adma
//   src_fin                   : source engine finished its last buffer
//   src_dat_o, src_dat64_o    : source read data [31:0] / [63:32]
//   src_xfer, dst_xfer        : per-beat data acks (push / pop)
//   src_start, src_end        : source burst throttles
//   dst_start, dst_end        : destination burst throttles
//   dst_dat_i, dst_dat64_i    : head entry [31:0] / [63:32] (show-ahead)
//   fifo_cnt                  : occupancy
//   fifo_ovf, fifo_udf        : sticky overflow / underflow flags
//   busy, xfer_done           : channel active / one-cycle drained pulse
module ss_dfifo
    import ss_dfifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned BURST = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_start,
    input  logic          cmd_abort,
    input  logic          src_fin,
    input  logic [31:0]   src_dat_o,
    input  logic [31:0]   src_dat64_o,
    input  logic          src_xfer,
    output logic          src_start,
    output logic          src_end,
    input  logic          dst_xfer,
    output logic          dst_start,
    output logic          dst_end,
    output logic [31:0]   dst_dat_i,
    output logic [31:0]   dst_dat64_i,
    output logic [AW:0]   fifo_cnt,
    output logic          fifo_ovf,
    output logic          fifo_udf,
    output logic          busy,
    output logic          xfer_done
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] BURST_C  = (AW+1)'(BURST);
    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

    df_state_e     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          active;
    logic          push_req, pop_req;
    logic          push, pop;
    logic [AW:0]   free_cnt;
    logic [DF_DW-1:0] head;

    // Acks are only honoured while the channel is running; in idle they are
    // ignored entirely and raise no flags.
    assign active   = (state_q != S_IDLE);
    assign push_req = src_xfer && active;
    assign pop_req  = dst_xfer && active;
    assign push     = push_req && (cnt_q < DEPTH_C);
    assign pop      = pop_req && (cnt_q != '0);
    assign free_cnt = DEPTH_C - cnt_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    state_d  = S_RUN;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    udf_d    = 1'b0;
                end
            end
            S_RUN:   if (src_fin) state_d = S_FLUSH;
            S_FLUSH: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
        if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
        if (push_req && !push) ovf_d = 1'b1;
        if (pop_req && !pop)   udf_d = 1'b1;

        // Abort overrides everything above, including cmd_start/src_fin and
        // any same-cycle beat; the sticky flags survive until the next start.
        if (cmd_abort) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    ss_dfifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({src_dat64_o, src_dat_o}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign src_start   = (state_q == S_RUN) && (free_cnt >= BURST_C);
    assign src_end     = (cnt_q >= DEPTH_M1);
    assign dst_start   = ((state_q == S_RUN) && (cnt_q >= BURST_C)) ||
                         ((state_q == S_FLUSH) && (cnt_q != '0));
    // Gated by active so every output reads 0 in idle / after reset.
    assign dst_end     = active && (cnt_q <= (AW+1)'(1));
    assign dst_dat_i   = head[31:0];
    assign dst_dat64_i = head[63:32];
    assign fifo_cnt    = cnt_q;
    assign fifo_ovf    = ovf_q;
    assign fifo_udf    = udf_q;
    assign busy        = active;
    assign xfer_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_ss_dfifo.sv
module tb_ss_dfifo;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_start, cmd_abort, src_fin;
    logic [31:0] src_dat_o, src_dat64_o;
    logic        src_xfer, dst_xfer;
    logic        src_start, src_end, dst_start, dst_end;
    logic [31:0] dst_dat_i, dst_dat64_i;
    logic [4:0]  fifo_cnt;
    logic        fifo_ovf, fifo_udf, busy, xfer_done;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    ss_dfifo #(.DEPTH(16), .AW(4), .BURST(4)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_start   (cmd_start),
        .cmd_abort   (cmd_abort),
        .src_fin     (src_fin),
        .src_dat_o   (src_dat_o),
        .src_dat64_o (src_dat64_o),
        .src_xfer    (src_xfer),
        .src_start   (src_start),
        .src_end     (src_end),
        .dst_xfer    (dst_xfer),
        .dst_start   (dst_start),
        .dst_end     (dst_end),
        .dst_dat_i   (dst_dat_i),
        .dst_dat64_i (dst_dat64_i),
        .fifo_cnt    (fifo_cnt),
        .fifo_ovf    (fifo_ovf),
        .fifo_udf    (fifo_udf),
        .busy        (busy),
        .xfer_done   (xfer_done)
    );

    typedef struct {
        logic        cs, ab, fin, sx, dx;
        logic [31:0] lo, hi;
        logic [4:0]  cnt;
        logic        sst, sen, dst, den, bsy, dn, ov, ud;
        logic        chk_dat;
        logic [31:0] elo, ehi;
    } vec_t;

    vec_t vt[$];
    logic [63:0] sb[$];

    function automatic vec_t row(logic cs, logic ab, logic fin, logic sx, logic dx,
                                 logic [31:0] lo, logic [31:0] hi, logic [4:0] cnt,
                                 logic sst, logic sen, logic dst, logic den,
                                 logic bsy, logic dn, logic ov, logic ud,
                                 logic chk_dat, logic [31:0] elo, logic [31:0] ehi);
        vec_t v;
        v.cs = cs; v.ab = ab; v.fin = fin; v.sx = sx; v.dx = dx;
        v.lo = lo; v.hi = hi; v.cnt = cnt;
        v.sst = sst; v.sen = sen; v.dst = dst; v.den = den;
        v.bsy = bsy; v.dn = dn; v.ov = ov; v.ud = ud;
        v.chk_dat = chk_dat; v.elo = elo; v.ehi = ehi;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [4:0] cnt,
                             input logic sst, input logic sen, input logic dst,
                             input logic den, input logic bsy, input logic dn,
                             input logic ov, input logic ud);
        chk({tag, "_cnt"},  32'(fifo_cnt),  32'(cnt));
        chk({tag, "_sst"},  32'(src_start), 32'(sst));
        chk({tag, "_sen"},  32'(src_end),   32'(sen));
        chk({tag, "_dst"},  32'(dst_start), 32'(dst));
        chk({tag, "_den"},  32'(dst_end),   32'(den));
        chk({tag, "_busy"}, 32'(busy),      32'(bsy));
        chk({tag, "_done"}, 32'(xfer_done), 32'(dn));
        chk({tag, "_ovf"},  32'(fifo_ovf),  32'(ov));
        chk({tag, "_udf"},  32'(fifo_udf),  32'(ud));
    endtask

    // One clock: inputs already driven, sample 1 time unit after the edge,
    // then release all pulse inputs.
    task automatic step();
        @(posedge wb_clk_i);
        #1;
        cmd_start = 1'b0; cmd_abort = 1'b0; src_fin = 1'b0;
        src_xfer = 1'b0; dst_xfer = 1'b0;
    endtask

    // Beat with scoreboard: pushes append, pops check the show-ahead head.
    task automatic beat(input string tag, input logic sx, input logic dx);
        logic [63:0] d;
        d = {$urandom, $urandom};
        src_dat_o = d[31:0]; src_dat64_o = d[63:32];
        src_xfer = sx; dst_xfer = dx;
        if (dx && sb.size() > 0) begin
            chk({tag, "_head"}, dst_dat_i, sb[0][31:0]);
            chk({tag, "_head64"}, dst_dat64_i, sb[0][63:32]);
            void'(sb.pop_front());
        end
        if (sx && fifo_cnt < 5'd16) sb.push_back(d);
        step();
    endtask

    initial begin
        logic [4:0] c;
        wb_rst_i = 1'b1;
        cmd_start = 1'b0; cmd_abort = 1'b0; src_fin = 1'b0;
        src_xfer = 1'b0; dst_xfer = 1'b0;
        src_dat_o = '0; src_dat64_o = '0;
        step();
        step();
        wb_rst_i = 1'b0;
        chk_state("reset", 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Test 1: start, 4 pushes, 4 pops.
        vt.push_back(row(1,0,0,0,0, 0,0, 5'd0, 1,0,0,1, 1,0,0,0, 0, 0,0));
        vt.push_back(row(0,0,0,1,0, 32'h1,32'hA, 5'd1, 1,0,0,1, 1,0,0,0, 1, 32'h1,32'hA));
        vt.push_back(row(0,0,0,1,0, 32'h2,32'hB, 5'd2, 1,0,0,0, 1,0,0,0, 1, 32'h1,32'hA));
        vt.push_back(row(0,0,0,1,0, 32'h3,32'hC, 5'd3, 1,0,0,0, 1,0,0,0, 1, 32'h1,32'hA));
        vt.push_back(row(0,0,0,1,0, 32'h4,32'hD, 5'd4, 1,0,1,0, 1,0,0,0, 1, 32'h1,32'hA));
        vt.push_back(row(0,0,0,0,1, 0,0, 5'd3, 1,0,0,0, 1,0,0,0, 1, 32'h2,32'hB));
        vt.push_back(row(0,0,0,0,1, 0,0, 5'd2, 1,0,0,0, 1,0,0,0, 1, 32'h3,32'hC));
        vt.push_back(row(0,0,0,0,1, 0,0, 5'd1, 1,0,0,1, 1,0,0,0, 1, 32'h4,32'hD));
        vt.push_back(row(0,0,0,0,1, 0,0, 5'd0, 1,0,0,1, 1,0,0,0, 0, 0,0));
        // Test 2: fill to full, then one overflowing push; head stays first entry.
        for (int n = 1; n <= 17; n++) begin
            c = (n <= 16) ? 5'(n) : 5'd16;
            vt.push_back(row(0,0,0,1,0, 32'h100 + 32'(n), 32'h200 + 32'(n), c,
                             (5'd16 - c) >= 5'd4, c >= 5'd15, c >= 5'd4, c <= 5'd1,
                             1, 0, n == 17, 0, 1, 32'h101, 32'h201));
        end

        for (int i = 0; i < vt.size(); i++) begin
            cmd_start = vt[i].cs; cmd_abort = vt[i].ab; src_fin = vt[i].fin;
            src_xfer = vt[i].sx; dst_xfer = vt[i].dx;
            src_dat_o = vt[i].lo; src_dat64_o = vt[i].hi;
            step();
            chk_state($sformatf("v%0d", i), vt[i].cnt, vt[i].sst, vt[i].sen, vt[i].dst,
                      vt[i].den, vt[i].bsy, vt[i].dn, vt[i].ov, vt[i].ud);
            if (vt[i].chk_dat) begin
                chk($sformatf("v%0d_dat", i), dst_dat_i, vt[i].elo);
                chk($sformatf("v%0d_dat64", i), dst_dat64_i, vt[i].ehi);
            end
        end

        // Abort keeps sticky ovf; next start clears it.
        cmd_abort = 1'b1; step();
        chk_state("abort1", 5'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        cmd_start = 1'b1; step();
        chk_state("start2", 5'd0, 1, 0, 0, 1, 1, 0, 0, 0);
        sb.delete();

        // Test 3: fill to 8, then 40 cycles of simultaneous push+pop.
        for (int i = 0; i < 8; i++) beat("t3fill", 1, 0);
        chk("t3_cnt8", 32'(fifo_cnt), 32'd8);
        for (int i = 0; i < 40; i++) begin
            beat($sformatf("t3_%0d", i), 1, 1);
            chk($sformatf("t3_%0d_cnt", i), 32'(fifo_cnt), 32'd8);
        end

        // Test 4: drain to 3, finish, flush the rest.
        for (int i = 0; i < 5; i++) beat("t4pop", 0, 1);
        chk_state("t4_cnt3", 5'd3, 1, 0, 0, 0, 1, 0, 0, 0);
        src_fin = 1'b1; step();
        chk_state("t4_flush", 5'd3, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) beat("t4flush", 0, 1);
        chk_state("t4_empty", 5'd0, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        chk_state("t4_done", 5'd0, 0, 0, 0, 1, 1, 1, 0, 0);
        step();
        chk_state("t4_idle", 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Test 5: underflow, abort at 9, start clears udf.
        cmd_start = 1'b1; step();
        sb.delete();
        dst_xfer = 1'b1; step();
        chk_state("t5_udf", 5'd0, 1, 0, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 9; i++) beat("t5fill", 1, 0);
        chk_state("t5_cnt9", 5'd9, 1, 0, 1, 0, 1, 0, 0, 1);
        cmd_abort = 1'b1; src_xfer = 1'b1; step();
        chk_state("t5_abort", 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
        cmd_start = 1'b1; step();
        chk_state("t5_start", 5'd0, 1, 0, 0, 1, 1, 0, 0, 0);
        sb.delete();

        // Test 6: reset mid-run with a same-cycle push.
        for (int i = 0; i < 6; i++) beat("t6fill", 1, 0);
        chk_state("t6_cnt6", 5'd6, 1, 0, 1, 0, 1, 0, 0, 0);
        wb_rst_i = 1'b1; src_xfer = 1'b1; step();
        wb_rst_i = 1'b0;
        chk_state("t6_rst", 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        src_xfer = 1'b1; dst_xfer = 1'b1; step();
        chk_state("t6_idle_xfer", 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
